// File: rtl/lane_game_engine_if.sv
// Video-side bundle of the lane game: raster position in, registered RGB out.
// The hvsync side is the master and the game engine is the slave.
interface lane_game_engine_if;
   logic [9:0] CounterX;
   logic [9:0] CounterY;
   logic       inDisplayArea;
   logic       vga_r;
   logic       vga_g;
   logic       vga_b;

   modport master (output CounterX, CounterY, inDisplayArea, input vga_r, vga_g, vga_b);
   modport slave  (input CounterX, CounterY, inDisplayArea, output vga_r, vga_g, vga_b);
endinterface

// File: rtl/lane_game_engine.sv
// Lane-crossing game core: player square, one scrolling block per lane,
// idle/play/win/lose sequencing, collision, score and registered 1-bit pixels.
//
// state  | meaning
// QI     | idle, positions held at reset values, wait for start
// QGAME  | playing, acts on tick: collide -> lose, top reached -> score, else move
// QWIN   | score reached MAX_SCORE, frozen until start drops
// QLOSE  | player hit a block, frozen until start drops
module lane_game_engine #(
   parameter int NUM_LANES  = 6,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int LANE_Y0    = 48,
   parameter int LANE_PITCH = 64,
   parameter int LANE_THICK = 8,
   parameter int BLOCK_W    = 20,
   parameter int SPEED      = 10,
   parameter int STEP       = 2,
   parameter int P_HALF     = 16,
   parameter int MAX_SCORE  = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                tick,
   input  logic                start,
   input  logic                btnU,
   input  logic                btnD,
   input  logic                btnL,
   input  logic                btnR,
   lane_game_engine_if.slave   vid,
   output logic [1:0]          state,
   output logic [3:0]          score,
   output logic [9:0]          player_x,
   output logic [9:0]          player_y,
   output logic                collision
);

   typedef enum logic [1:0] {QI = 2'b00, QGAME = 2'b01, QWIN = 2'b10, QLOSE = 2'b11} state_t;

   localparam logic [9:0]  PX0    = 10'(SCREEN_W / 2);
   localparam logic [9:0]  PY0    = 10'(SCREEN_H - 1 - P_HALF);
   localparam logic [9:0]  P_LO   = 10'(P_HALF);
   localparam logic [9:0]  X_HI   = 10'(SCREEN_W - 1 - P_HALF);
   localparam logic [9:0]  Y_HI   = 10'(SCREEN_H - 1 - P_HALF);
   localparam logic [10:0] PH     = 11'(P_HALF);
   localparam logic [10:0] STP    = 11'(STEP);
   localparam logic [10:0] LO_LIM = 11'(P_HALF + STEP);
   localparam logic [10:0] X_HI11 = 11'(SCREEN_W - 1 - P_HALF);
   localparam logic [10:0] Y_HI11 = 11'(SCREEN_H - 1 - P_HALF);
   localparam logic [10:0] SPD    = 11'(SPEED);
   localparam logic [10:0] SW     = 11'(SCREEN_W);
   localparam logic [10:0] BW_M1  = 11'(BLOCK_W - 1);
   localparam logic [10:0] LT     = 11'(LANE_THICK);
   localparam logic [10:0] BX_SPN = 11'(BLOCK_W - 1 + P_HALF);
   localparam logic [10:0] LY_SPN = 11'(LANE_THICK - 1 + P_HALF);
   localparam logic [3:0]  WIN_SC = 4'(MAX_SCORE);

   state_t      state_q, state_d;
   logic [3:0]  score_d;
   logic [9:0]  px_d, py_d;
   logic [9:0]  block_x [NUM_LANES];
   logic [9:0]  block_x_d [NUM_LANES];
   logic        pix_r, pix_g, pix_b;
   logic [10:0] px11, py11, cx11, cy11;

   function automatic logic [9:0] block_rst(input int i);
      return 10'(i * (SCREEN_W / NUM_LANES));
   endfunction

   function automatic logic [10:0] lane_y0(input int i);
      return 11'(LANE_Y0 + i * LANE_PITCH);
   endfunction

   assign state = state_q;
   assign px11  = {1'b0, player_x};
   assign py11  = {1'b0, player_y};
   assign cx11  = {1'b0, vid.CounterX};
   assign cy11  = {1'b0, vid.CounterY};

   // Both sides are shifted by P_HALF so the compares never go negative.
   always_comb begin
      collision = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (({1'b0, block_x[i]} <= px11 + PH) && ({1'b0, block_x[i]} + BX_SPN >= px11) &&
             (lane_y0(i) <= py11 + PH) && (lane_y0(i) + LY_SPN >= py11))
            collision = 1'b1;
      end
   end

   always_comb begin
      pix_r = (cx11 + PH >= px11) && (cx11 <= px11 + PH) &&
              (cy11 + PH >= py11) && (cy11 <= py11 + PH);
      pix_g = 1'b0;
      pix_b = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if ((cy11 >= lane_y0(i)) && (cy11 < lane_y0(i) + LT)) begin
            if ((cx11 >= {1'b0, block_x[i]}) && (cx11 <= {1'b0, block_x[i]} + BW_M1))
               pix_g = 1'b1;
            else
               pix_b = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      score_d = score;
      px_d    = player_x;
      py_d    = player_y;
      for (int i = 0; i < NUM_LANES; i++) block_x_d[i] = block_x[i];

      case (state_q)
         QI: begin
            px_d = PX0;
            py_d = PY0;
            for (int i = 0; i < NUM_LANES; i++) block_x_d[i] = block_rst(i);
            if (start) begin
               state_d = QGAME;
               score_d = 4'd0;
            end
         end
         QGAME: begin
            if (tick) begin
               if (collision) begin
                  state_d = QLOSE;
               end else if (player_y == P_LO) begin
                  score_d = score + 4'd1;
                  px_d    = PX0;
                  py_d    = PY0;
                  if (score_d == WIN_SC) state_d = QWIN;
               end else begin
                  if (btnD && !btnU)
                     py_d = (py11 + STP > Y_HI11) ? Y_HI : 10'(py11 + STP);
                  else if (btnU && !btnD)
                     py_d = (py11 < LO_LIM) ? P_LO : 10'(py11 - STP);
                  else if (btnR && !btnL)
                     px_d = (px11 + STP > X_HI11) ? X_HI : 10'(px11 + STP);
                  else if (btnL && !btnR)
                     px_d = (px11 < LO_LIM) ? P_LO : 10'(px11 - STP);
                  for (int i = 0; i < NUM_LANES; i++) begin
                     if (i % 2 == 0)
                        block_x_d[i] = ({1'b0, block_x[i]} + SPD >= SW) ?
                                       10'({1'b0, block_x[i]} + SPD - SW) :
                                       10'({1'b0, block_x[i]} + SPD);
                     else
                        block_x_d[i] = ({1'b0, block_x[i]} < SPD) ?
                                       10'({1'b0, block_x[i]} + SW - SPD) :
                                       10'({1'b0, block_x[i]} - SPD);
                  end
               end
            end
         end
         default: begin
            if (!start) begin
               state_d = QI;
               px_d    = PX0;
               py_d    = PY0;
               for (int i = 0; i < NUM_LANES; i++) block_x_d[i] = block_rst(i);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= QI;
         score    <= 4'd0;
         player_x <= PX0;
         player_y <= PY0;
         for (int i = 0; i < NUM_LANES; i++) block_x[i] <= block_rst(i);
         vid.vga_r <= 1'b0;
         vid.vga_g <= 1'b0;
         vid.vga_b <= 1'b0;
      end else begin
         state_q  <= state_d;
         score    <= score_d;
         player_x <= px_d;
         player_y <= py_d;
         for (int i = 0; i < NUM_LANES; i++) block_x[i] <= block_x_d[i];
         vid.vga_r <= pix_r & vid.inDisplayArea;
         vid.vga_g <= pix_g & vid.inDisplayArea;
         vid.vga_b <= pix_b & vid.inDisplayArea;
      end
   end

endmodule

// File: tb/tb_lane_game_engine.sv
// Directed bench for lane_game_engine: dut_a runs default parameters,
// dut_b runs with static blocks and a one-crossing win for collision/win cases.
module tb_lane_game_engine;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0, start = 1'b0;
   logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
   logic [1:0] state_a, state_b;
   logic [3:0] score_a, score_b;
   logic [9:0] px_a, py_a, px_b, py_b;
   logic       col_a, col_b;
   int         n_checks = 0;
   int         n_pass = 0;
   int         exp_bx [6] = '{0, 106, 212, 318, 424, 530};

   lane_game_engine_if vif_a ();
   lane_game_engine_if vif_b ();

   always #5 clk = ~clk;

   lane_game_engine dut_a (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
      .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .vid(vif_a),
      .state(state_a), .score(score_a), .player_x(px_a), .player_y(py_a), .collision(col_a)
   );

   lane_game_engine #(.SPEED(0), .MAX_SCORE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
      .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .vid(vif_b),
      .state(state_b), .score(score_b), .player_x(px_b), .player_y(py_b), .collision(col_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         cyc();
      end
   endtask

   task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic ind);
      vif_a.CounterX = x;  vif_a.CounterY = y;  vif_a.inDisplayArea = ind;
      vif_b.CounterX = x;  vif_b.CounterY = y;  vif_b.inDisplayArea = ind;
   endtask

   initial begin
      set_pix(10'd0, 10'd0, 1'b0);
      // tick/start while held in reset must be ignored
      repeat (3) begin
         tick = 1'b1; start = 1'b1;
         cyc();
      end
      tick = 1'b0; start = 1'b0;
      reset_n = 1'b1;
      do_ticks(5);
      check("rst_state", state_a, 2'b00);
      check("rst_score", score_a, 4'd0);
      check("rst_px", px_a, 10'd320);
      check("rst_py", py_a, 10'd463);
      for (int i = 0; i < 6; i++) check($sformatf("rst_bx%0d", i), dut_a.block_x[i], exp_bx[i]);
      check("rst_vga", {vif_a.vga_r, vif_a.vga_g, vif_a.vga_b}, 3'b000);

      // pixels in QI
      set_pix(10'd320, 10'd463, 1'b1);
      check("vga_r_lag", vif_a.vga_r, 1'b0);
      cyc();
      check("vga_r_on", vif_a.vga_r, 1'b1);
      set_pix(10'd320, 10'd463, 1'b0);
      cyc();
      check("vga_r_blank", vif_a.vga_r, 1'b0);
      set_pix(10'd5, 10'd48, 1'b1);
      cyc();
      check("vga_g_blk0", vif_a.vga_g, 1'b1);
      check("vga_b_blk0", vif_a.vga_b, 1'b0);
      set_pix(10'd100, 10'd48, 1'b1);
      cyc();
      check("vga_g_lane0", vif_a.vga_g, 1'b0);
      check("vga_b_lane0", vif_a.vga_b, 1'b1);
      set_pix(10'd0, 10'd0, 1'b0);

      // QI->QGAME with a coincident tick: tick ignored
      start = 1'b1; tick = 1'b1; btnU = 1'b1;
      cyc();
      tick = 1'b0;
      check("go_state", state_a, 2'b01);
      check("go_py", py_a, 10'd463);
      check("go_bx0", dut_a.block_x[0], 10'd0);
      do_ticks(3);
      check("mv_py", py_a, 10'd457);
      check("mv_bx0", dut_a.block_x[0], 10'd30);
      check("mv_bx1", dut_a.block_x[1], 10'd76);
      check("mv_score", score_a, 4'd0);

      btnU = 1'b0;
      do_ticks(7);
      check("bx1_pre_wrap", dut_a.block_x[1], 10'd6);
      do_ticks(1);
      check("bx1_wrap", dut_a.block_x[1], 10'd636);
      do_ticks(52);
      check("bx0_pre_wrap", dut_a.block_x[0], 10'd630);
      do_ticks(1);
      check("bx0_wrap", dut_a.block_x[0], 10'd0);
      btnU = 1'b1; btnD = 1'b1;
      do_ticks(1);
      check("ud_py", py_a, 10'd457);
      check("ud_px", px_a, 10'd320);
      btnU = 1'b0; btnD = 1'b0; btnR = 1'b1;
      do_ticks(1);
      check("r_px", px_a, 10'd322);

      // async reset in the middle of a game
      reset_n = 1'b0;
      #2;
      check("async_state", state_a, 2'b00);
      check("async_px", px_a, 10'd320);
      check("async_py", py_a, 10'd463);
      btnR = 1'b0; start = 1'b0;
      cyc();
      reset_n = 1'b1;

      // win on dut_b: sidestep to x=80, then climb to the top
      start = 1'b1;
      cyc();
      btnL = 1'b1;
      do_ticks(120);
      check("win_px", px_b, 10'd80);
      check("win_py0", py_b, 10'd463);
      btnL = 1'b0; btnU = 1'b1;
      do_ticks(223);
      check("win_py17", py_b, 10'd17);
      do_ticks(1);
      check("win_clamp", py_b, 10'd16);
      check("win_st_game", state_b, 2'b01);
      check("win_col", col_b, 1'b0);
      do_ticks(1);
      check("win_score", score_b, 4'd1);
      check("win_state", state_b, 2'b10);
      check("win_px_home", px_b, 10'd320);
      check("win_py_home", py_b, 10'd463);
      do_ticks(1);
      check("win_frozen_st", state_b, 2'b10);
      check("win_frozen_py", py_b, 10'd463);
      start = 1'b0;
      cyc();
      check("win_to_qi", state_b, 2'b00);
      check("win_score_hold", score_b, 4'd1);
      reset_n = 1'b0;
      #2;
      check("async_score", score_b, 4'd0);
      cyc();
      reset_n = 1'b1;

      // collision on dut_b against lane 3 block (x 318..337)
      start = 1'b1;
      cyc();
      check("col_go", state_b, 2'b01);
      do_ticks(99);
      check("col_py265", py_b, 10'd265);
      check("col_off", col_b, 1'b0);
      do_ticks(1);
      check("col_py263", py_b, 10'd263);
      check("col_on", col_b, 1'b1);
      do_ticks(1);
      check("lose_state", state_b, 2'b11);
      check("lose_py", py_b, 10'd263);
      start = 1'b0;
      cyc();
      check("lose_to_qi", state_b, 2'b00);
      check("lose_py_home", py_b, 10'd463);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
